ram_arbiter: RTL

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter
//   Two-requester round-robin arbiter in front of a single shared RAM
//   line interface. Requests that arrive while a transaction is in
//   flight wait for the next IDLE cycle. Only one request is ever
//   outstanding on the RAM side.
//
// Optional feature:
//   ARB_TIMEOUT_EN - adds a watchdog on the ISSUE state. The RAM gets
//                    TIMEOUT_CYCLES cycles to answer. If it does not,
//                    the requester is acked with zero data and
//                    timeout_err is set. timeout_err stays set until
//                    reset.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   rN_avalid/rnw/addr/wdata   requester N line request (N = 0, 1)
//   rN_rdata, rN_ack           fill data and one-cycle completion pulse
//   m_avalid/rnw/addr/wdata    registered request toward the RAM
//   m_rdata, m_ack             RAM fill data and completion pulse
//   grant                      current/last granted requester
//   busy                       arbiter not idle
//   timeout_err                sticky watchdog flag (0 without ARB_TIMEOUT_EN)
module ram_arbiter #(
  parameter int RAM_ADDR_SIZE  = 13,
  parameter int LINE_WIDTH     = 64,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     r0_avalid,
  input  logic                     r0_rnw,
  input  logic [RAM_ADDR_SIZE-1:0] r0_addr,
  input  logic [LINE_WIDTH-1:0]    r0_wdata,
  output logic [LINE_WIDTH-1:0]    r0_rdata,
  output logic                     r0_ack,
  input  logic                     r1_avalid,
  input  logic                     r1_rnw,
  input  logic [RAM_ADDR_SIZE-1:0] r1_addr,
  input  logic [LINE_WIDTH-1:0]    r1_wdata,
  output logic [LINE_WIDTH-1:0]    r1_rdata,
  output logic                     r1_ack,
  output logic                     m_avalid,
  output logic                     m_rnw,
  output logic [RAM_ADDR_SIZE-1:0] m_addr,
  output logic [LINE_WIDTH-1:0]    m_wdata,
  input  logic [LINE_WIDTH-1:0]    m_rdata,
  input  logic                     m_ack,
  output logic                     grant,
  output logic                     busy,
  output logic                     timeout_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t state, state_next;
  logic   pick;
  logic   start;
  logic   finish;
  logic   expire;
  logic   timeout_hit;

  // State register. Reset drops straight to IDLE, even in the middle of a
  // RAM transaction, so m_avalid and busy fall without waiting for a clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state and arbitration decision. On a tie, the requester that was
  // not granted last time wins. In ISSUE the requests are not looked at,
  // so the other requester cannot disturb a transaction in flight. DONE
  // always returns to IDLE. That extra cycle stops a requester that is
  // still holding avalid during its ack cycle from being granted again.
  always_comb begin
    state_next = state;
    pick       = grant;
    start      = 1'b0;
    finish     = 1'b0;
    expire     = 1'b0;
    case (state)
      IDLE: begin
        if (r0_avalid && r1_avalid) begin
          pick  = ~grant;
          start = 1'b1;
        end else if (r0_avalid) begin
          pick  = 1'b0;
          start = 1'b1;
        end else if (r1_avalid) begin
          pick  = 1'b1;
          start = 1'b1;
        end
        if (start) state_next = ISSUE;
      end
      ISSUE: begin
        if (m_ack) begin
          finish     = 1'b1;
          state_next = DONE;
        end else if (timeout_hit) begin
          expire     = 1'b1;
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request latch, grant pointer, and completion toward the requesters.
  // The m_* copy is taken once, when the request is granted, and is not
  // updated again until the next grant. A write completion leaves the
  // requester's rdata unchanged. A watchdog expiry returns zero data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant    <= 1'b1;
      m_rnw    <= 1'b1;
      m_addr   <= '0;
      m_wdata  <= '0;
      r0_ack   <= 1'b0;
      r1_ack   <= 1'b0;
      r0_rdata <= '0;
      r1_rdata <= '0;
    end else begin
      r0_ack <= 1'b0;
      r1_ack <= 1'b0;
      if (start) begin
        grant   <= pick;
        m_rnw   <= pick ? r1_rnw   : r0_rnw;
        m_addr  <= pick ? r1_addr  : r0_addr;
        m_wdata <= pick ? r1_wdata : r0_wdata;
      end
      if (finish || expire) begin
        if (grant) r1_ack <= 1'b1;
        else       r0_ack <= 1'b1;
      end
      if (finish && m_rnw) begin
        if (grant) r1_rdata <= m_rdata;
        else       r0_rdata <= m_rdata;
      end
      if (expire) begin
        if (grant) r1_rdata <= '0;
        else       r0_rdata <= '0;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] issue_cnt;

  // The watchdog counts the cycles spent in ISSUE. It restarts on every
  // grant. The expiry cycle is the last of TIMEOUT_CYCLES ISSUE cycles.
  // If m_ack arrives in that same cycle, m_ack wins (see the ISSUE branch).
  assign timeout_hit = (issue_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      issue_cnt   <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (start)                issue_cnt <= '0;
      else if (state == ISSUE)  issue_cnt <= issue_cnt + 1'b1;
      if (expire)               timeout_err <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign m_avalid = (state == ISSUE);
  assign busy     = (state != IDLE);

endmodule
